// File: rtl/hl_rmii_pkg.sv
// Shared types and constants for the RMII receive path.
package hl_rmii_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_LO,
      ST_HI
   } rx_state_e;

   localparam logic [1:0] DIBIT_PRE       = 2'b01;
   localparam int         MAX_NIBBLES_DEF = 3072;
   localparam int         DIV10_DEF       = 10;

endpackage

// File: rtl/rmii_sample_tick.sv
// Dibit sample strobe: every clk at 100 Mb/s, mid-dibit once per DIV10 clks at 10 Mb/s.
module rmii_sample_tick
   import hl_rmii_pkg::*;
#(
   parameter int DIV10 = DIV10_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic speed_10,
   input  logic restart,
   output logic tick
);

   localparam int             CW   = (DIV10 > 1) ? $clog2(DIV10) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DIV10 - 1);
   localparam logic [CW-1:0]  HALF = CW'(DIV10 / 2);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The restart clk itself never samples, so the first dibit is not seen twice.
   assign tick = speed_10 ? ((cnt_q == HALF) && !restart) : 1'b1;

endmodule

// File: rtl/rmii_rx_nibbler.sv
// RMII dibit to MII nibble converter with preamble sync, frame length and error flags.
//
//   state   | meaning
//   IDLE    | no frame; wait for crs_dv (or for crs_dv low after a forced end)
//   SYNC    | carrier up, hunting for the first preamble dibit
//   LO      | next tick is the low dibit of a nibble; crs_dv ignored
//   HI      | next tick is the high dibit; crs_dv low ends the frame
module rmii_rx_nibbler
   import hl_rmii_pkg::*;
#(
   parameter int MAX_NIBBLES = MAX_NIBBLES_DEF,
   parameter int DIV10       = DIV10_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  rmii_rxd,
   input  logic        rmii_crs_dv,
   input  logic        speed_10,
   output logic [3:0]  mii_rxd,
   output logic        mii_rx_dv,
   output logic        nibble_stb,
   output logic        rx_er,
   output logic [11:0] frame_len
);

   localparam logic [11:0] MAX_CNT = 12'(MAX_NIBBLES);

   logic [1:0]  rst_sync_q;
   logic        rst_int_n;
   logic        tick;
   logic        restart;

   rx_state_e   state_q;
   logic [1:0]  low_q;
   logic [11:0] count_q;
   logic        blocked_q;
   logic        crs_prev_q;
   logic [3:0]  mii_rxd_q;
   logic        rx_dv_q;
   logic        stb_q;
   logic        rx_er_q;
   logic [11:0] frame_len_q;

   // Assert asynchronously, release two clks later so no tick precedes it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];
   assign restart   = (state_q == ST_IDLE) && rmii_crs_dv && !crs_prev_q;

   rmii_sample_tick #(
      .DIV10    (DIV10)
   ) u_tick (
      .clk      (clk),
      .resetn   (rst_int_n),
      .speed_10 (speed_10),
      .restart  (restart),
      .tick     (tick)
   );

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= ST_IDLE;
         low_q       <= 2'b00;
         count_q     <= '0;
         blocked_q   <= 1'b0;
         crs_prev_q  <= 1'b0;
         mii_rxd_q   <= 4'h0;
         rx_dv_q     <= 1'b0;
         stb_q       <= 1'b0;
         rx_er_q     <= 1'b0;
         frame_len_q <= '0;
      end else begin
         stb_q      <= 1'b0;
         rx_er_q    <= 1'b0;
         crs_prev_q <= rmii_crs_dv;
         if (tick) begin
            case (state_q)
               ST_IDLE: begin
                  if (blocked_q) begin
                     if (!rmii_crs_dv) blocked_q <= 1'b0;
                  end else if (rmii_crs_dv) begin
                     state_q <= ST_SYNC;
                  end
               end
               ST_SYNC: begin
                  if (!rmii_crs_dv) begin
                     state_q <= ST_IDLE;
                  end else if (rmii_rxd == DIBIT_PRE) begin
                     low_q   <= rmii_rxd;
                     state_q <= ST_HI;
                  end
               end
               ST_LO: begin
                  // Over-length is caught one tick after the limiting nibble went out.
                  if (count_q >= MAX_CNT) begin
                     rx_er_q     <= 1'b1;
                     rx_dv_q     <= 1'b0;
                     frame_len_q <= MAX_CNT;
                     count_q     <= '0;
                     blocked_q   <= 1'b1;
                     state_q     <= ST_IDLE;
                  end else begin
                     low_q   <= rmii_rxd;
                     state_q <= ST_HI;
                  end
               end
               ST_HI: begin
                  if (rmii_crs_dv) begin
                     mii_rxd_q <= {rmii_rxd, low_q};
                     stb_q     <= 1'b1;
                     rx_dv_q   <= 1'b1;
                     if (count_q != '1) count_q <= count_q + 12'd1;
                     state_q   <= ST_LO;
                  end else begin
                     rx_dv_q     <= 1'b0;
                     frame_len_q <= count_q;
                     rx_er_q     <= count_q[0];
                     count_q     <= '0;
                     state_q     <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign mii_rxd    = mii_rxd_q;
   assign mii_rx_dv  = rx_dv_q;
   assign nibble_stb = stb_q;
   assign rx_er      = rx_er_q;
   assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_rmii_rx_nibbler.sv
// Directed frame table plus reset and over-length sequences for rmii_rx_nibbler.
module tb_rmii_rx_nibbler;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  rmii_rxd = 2'b00;
   logic        rmii_crs_dv = 1'b0;
   logic        speed_10 = 1'b0;
   logic [3:0]  mii_rxd;
   logic        mii_rx_dv;
   logic        nibble_stb;
   logic        rx_er;
   logic [11:0] frame_len;

   rmii_rx_nibbler dut (
      .clk         (clk),
      .resetn      (resetn),
      .rmii_rxd    (rmii_rxd),
      .rmii_crs_dv (rmii_crs_dv),
      .speed_10    (speed_10),
      .mii_rxd     (mii_rxd),
      .mii_rx_dv   (mii_rx_dv),
      .nibble_stb  (nibble_stb),
      .rx_er       (rx_er),
      .frame_len   (frame_len)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic spd;
      int   ndata;
      logic tog;
      int   seed;
      int   exp_len;
      int   exp_stb;
      int   exp_er;
      logic ovf;
   } vec_t;

   vec_t vecs[7];

   int total = 0;
   int bad   = 0;

   int   got_q[$];
   int   stb_cyc[$];
   int   exp_q[$];
   int   cyc = 0;
   int   er_cnt = 0;
   int   er_cyc = 0;
   int   dv_bad = 0;
   int   dbl_cnt = 0;
   logic stb_prev = 1'b0;
   logic er_prev = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (nibble_stb) begin
         got_q.push_back(int'(mii_rxd));
         stb_cyc.push_back(cyc);
         if (!mii_rx_dv) dv_bad = dv_bad + 1;
      end
      if (rx_er) begin
         er_cnt = er_cnt + 1;
         er_cyc = cyc;
      end
      if ((nibble_stb && stb_prev) || (rx_er && er_prev)) dbl_cnt = dbl_cnt + 1;
      stb_prev = nibble_stb;
      er_prev  = rx_er;
   end

   task automatic chk(input string name, input int got, input int exp);
      total = total + 1;
      if (got != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      stb_cyc.delete();
      exp_q.delete();
      er_cnt = 0;
      dv_bad = 0;
   endtask

   task automatic drive(input logic crs, input logic [1:0] d);
      rmii_crs_dv = crs;
      rmii_rxd    = d;
      repeat (speed_10 ? 10 : 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      rmii_crs_dv = 1'b0;
      rmii_rxd    = 2'b00;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int nib;
      int sp_bad;
      clear_mon();
      speed_10 = v.spd;
      idle(5);
      drive(1'b1, 2'b00);
      drive(1'b1, 2'b00);
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 2'b01);
         drive(1'b1, 2'b01);
         exp_q.push_back(5);
      end
      drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      exp_q.push_back(13);
      for (int i = 0; i < v.ndata; i++) begin
         nib = (v.seed + 3 * i) & 15;
         drive(1'b1, 2'(nib & 3));
         drive(1'b1, 2'((nib >> 2) & 3));
         exp_q.push_back(nib);
      end
      if (v.tog) begin
         drive(1'b0, 2'b10);
         drive(1'b1, 2'b01);
         exp_q.push_back(6);
         drive(1'b0, 2'b11);
         drive(1'b1, 2'b00);
         exp_q.push_back(3);
      end
      drive(!v.tog, 2'b00);
      if (!v.spd && !v.ovf) begin
         rmii_crs_dv = 1'b0;
         rmii_rxd    = 2'b00;
         @(negedge clk);
         #1;
         chk($sformatf("v%0d dv before end tick", idx), int'(mii_rx_dv), 1);
         @(negedge clk);
         #1;
         chk($sformatf("v%0d dv after end tick", idx), int'(mii_rx_dv), 0);
         @(posedge clk);
         #1;
      end else begin
         drive(1'b0, 2'b00);
      end
      idle(30);
      chk($sformatf("v%0d stb count", idx), got_q.size(), v.exp_stb);
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk($sformatf("v%0d nibble[%0d]", idx, i), got_q[i], exp_q[i]);
      chk($sformatf("v%0d frame_len", idx), int'(frame_len), v.exp_len);
      chk($sformatf("v%0d rx_er pulses", idx), er_cnt, v.exp_er);
      chk($sformatf("v%0d stb without dv", idx), dv_bad, 0);
      chk($sformatf("v%0d dv idle", idx), int'(mii_rx_dv), 0);
      sp_bad = 0;
      for (int i = 1; i < stb_cyc.size(); i++)
         if (stb_cyc[i] - stb_cyc[i-1] != (v.spd ? 20 : 2)) sp_bad = sp_bad + 1;
      chk($sformatf("v%0d stb spacing errs", idx), sp_bad, 0);
      if (v.exp_er != 0 && stb_cyc.size() > 0)
         chk($sformatf("v%0d rx_er timing", idx), er_cyc - stb_cyc[stb_cyc.size()-1],
             v.ovf ? 1 : (v.spd ? 20 : 2));
   endtask

   initial begin
      //           spd   ndata tog   seed exp_len exp_stb exp_er ovf
      vecs[0] = '{1'b0, 8,    1'b0, 1,   24,     24,     0,     1'b0};
      vecs[1] = '{1'b0, 8,    1'b1, 7,   26,     26,     0,     1'b0};
      vecs[2] = '{1'b1, 8,    1'b0, 1,   24,     24,     0,     1'b0};
      vecs[3] = '{1'b0, 7,    1'b0, 4,   23,     23,     1,     1'b0};
      vecs[4] = '{1'b1, 7,    1'b0, 9,   23,     23,     1,     1'b0};
      vecs[5] = '{1'b0, 3084, 1'b0, 2,   3072,   3072,   1,     1'b1};
      vecs[6] = '{1'b0, 8,    1'b0, 11,  24,     24,     0,     1'b0};

      repeat (3) @(negedge clk);
      #1;
      chk("reset mii_rxd", int'(mii_rxd), 0);
      chk("reset rx_dv", int'(mii_rx_dv), 0);
      chk("reset stb", int'(nibble_stb), 0);
      chk("reset rx_er", int'(rx_er), 0);
      chk("reset frame_len", int'(frame_len), 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(5);

      clear_mon();
      drive(1'b1, 2'b00);
      drive(1'b1, 2'b00);
      for (int i = 0; i < 20; i++) drive(1'b1, 2'b01);
      @(negedge clk);
      #1;
      chk("pre-reset stb count", got_q.size(), 10);
      if (got_q.size() > 0) chk("pre-reset nibble", got_q[got_q.size()-1], 5);
      resetn      = 1'b0;
      rmii_crs_dv = 1'b0;
      rmii_rxd    = 2'b00;
      @(negedge clk);
      #1;
      chk("midreset rx_dv", int'(mii_rx_dv), 0);
      chk("midreset stb", int'(nibble_stb), 0);
      chk("midreset mii_rxd", int'(mii_rxd), 0);
      chk("midreset frame_len", int'(frame_len), 0);
      chk("midreset rx_er pulses", er_cnt, 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(5);
      chk("post-reset frame_len", int'(frame_len), 0);

      for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

      chk("back-to-back stb/er", dbl_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
